// File: rtl/mc_control_pkg.sv
// Shared opcode constants, FSM state, ALU/error encodings and the decoded control bundle
// for the mc_control multi-cycle controller.
package mc_control_pkg;

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpOp32    = 7'b0111011;

    localparam logic [31:0] InstrEbreak = 32'h0010_0073;

    typedef enum logic [1:0] {AluAdd, AluBranch, AluFunct, AluPassImm} alu_op_e;

    typedef enum logic [1:0] {ErrNone, ErrIllegal, ErrTimeout} err_e;

    typedef enum logic [2:0] {
        StFetch, StWaitI, StDecode, StExec, StMem, StWaitM, StWb, StHalt
    } state_e;

    typedef struct packed {
        logic    alu_src;
        alu_op_e alu_op;
        logic    alu_word;
        logic    mem2reg;
        logic    reg_write;
        logic    branch;
        logic    jump;
        logic    is_load;
        logic    is_store;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder for mc_control. RV64W_EN enables the 32-bit word
// opcodes (only when XLEN is 64); otherwise they decode as illegal.
module mc_decode
    import mc_control_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       legal
);

`ifdef RV64W_EN
    localparam bit MacroEn = 1'b1;
`else
    localparam bit MacroEn = 1'b0;
`endif
    localparam bit WordEn = MacroEn && (XLEN == 64);

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (opcode)
            OpLoad: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem2reg   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.is_load   = 1'b1;
            end
            OpOpImm: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = AluFunct;
                ctrl.reg_write = 1'b1;
            end
            OpStore: begin
                ctrl.alu_src  = 1'b1;
                ctrl.is_store = 1'b1;
            end
            OpOp: begin
                ctrl.alu_op    = AluFunct;
                ctrl.reg_write = 1'b1;
            end
            OpBranch: begin
                ctrl.alu_op = AluBranch;
                ctrl.branch = 1'b1;
            end
            OpLui: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = AluPassImm;
                ctrl.reg_write = 1'b1;
            end
            OpAuipc: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OpJal: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OpJalr: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OpSystem: ;
            OpOpImm32: begin
                if (WordEn) begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = AluFunct;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_word  = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OpOp32: begin
                if (WordEn) begin
                    ctrl.alu_op    = AluFunct;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_word  = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle instruction controller: fetch/decode/exec/mem/writeback FSM with a shared
// handshake timeout counter. Optional RV64W_EN macro enables word opcodes in mc_decode.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_resp_valid,
    input  logic [31:0] instr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    input  logic        mem_resp_valid,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        alu_word,
    output logic        mem2reg,
    output logic        reg_write,
    output logic        pc_write,
    output logic        branch,
    output logic        jump,
    output logic        halt,
    output logic [1:0]  err,
    output logic [2:0]  state
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [1:0]       err_q, err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    ctrl_t            dec_ctrl;
    logic             dec_legal;
    logic             expired;

    mc_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .opcode(instr_q[6:0]),
        .ctrl  (dec_ctrl),
        .legal (dec_legal)
    );

    // A handshake in the final allowed cycle is checked first, so it beats the timeout.
    assign expired = (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
        cnt_d   = '0;
        case (state_q)
            StFetch: begin
                if (ifu_req_ready) begin
                    state_d = StWaitI;
                end else if (expired) begin
                    state_d = StHalt;
                    err_d   = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitI: begin
                if (ifu_resp_valid) begin
                    instr_d = instr;
                    state_d = StDecode;
                end else if (expired) begin
                    state_d = StHalt;
                    err_d   = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecode: begin
                ctrl_d = dec_ctrl;
                if (!dec_legal) begin
                    state_d = StHalt;
                    err_d   = ErrIllegal;
                end else if (instr_q == InstrEbreak) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: state_d = (ctrl_q.is_load || ctrl_q.is_store) ? StMem : StWb;
            StMem: begin
                if (mem_req_ready) begin
                    state_d = ctrl_q.is_store ? StWb : StWaitM;
                end else if (expired) begin
                    state_d = StHalt;
                    err_d   = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitM: begin
                if (mem_resp_valid) begin
                    state_d = StWb;
                end else if (expired) begin
                    state_d = StHalt;
                    err_d   = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb:   state_d = StFetch;
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            instr_q <= '0;
            ctrl_q  <= '0;
            err_q   <= ErrNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fetch request is masked during reset so every output reads zero while rst is high.
    always_comb begin
        ifu_req_valid = (state_q == StFetch) && !rst;
        mem_req_valid = (state_q == StMem);
        mem_we        = (state_q == StMem) && ctrl_q.is_store;
        alu_src       = ctrl_q.alu_src;
        alu_op        = ctrl_q.alu_op;
        alu_word      = ctrl_q.alu_word;
        mem2reg       = ctrl_q.mem2reg;
        branch        = ctrl_q.branch;
        jump          = ctrl_q.jump;
        reg_write     = (state_q == StWb) && ctrl_q.reg_write;
        pc_write      = (state_q == StWb);
        halt          = (state_q == StHalt);
        err           = err_q;
        state         = state_q;
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes expected retire/halt records,
// a monitor pops them on pc_write or halt and checks controls, latency and error code.
module tb_mc_control;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TO   = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] instr;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic        alu_src, alu_word, mem2reg, reg_write, pc_write, branch, jump, halt;
    logic [1:0]  alu_op, err;
    logic [2:0]  state;

    mc_control #(
        .XLEN       (XLEN),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid),
        .instr         (instr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_resp_valid(mem_resp_valid),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .alu_word      (alu_word),
        .mem2reg       (mem2reg),
        .reg_write     (reg_write),
        .pc_write      (pc_write),
        .branch        (branch),
        .jump          (jump),
        .halt          (halt),
        .err           (err),
        .state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       halt;
        bit [1:0] err;
        bit       src;
        bit [1:0] op;
        bit       word, m2r, rw, br, jmp, mem, store;
        int       lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fetch_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Expected behaviour from the opcode table: controls, halt/err and end-to-end latency.
    function automatic exp_t model(input logic [31:0] w, input int wi, input int wv,
                                   input int wr, input int wm);
        exp_t e = '{default: 0};
        bit   w_en;
`ifdef RV64W_EN
        w_en = (XLEN == 64);
`else
        w_en = 1'b0;
`endif
        e.lat = 5 + wi + wv;
        case (w[6:0])
            7'h03: begin e.src = 1; e.m2r = 1; e.rw = 1; e.mem = 1; e.lat += 2 + wr + wm; end
            7'h13: begin e.src = 1; e.op = 2; e.rw = 1; end
            7'h23: begin e.src = 1; e.mem = 1; e.store = 1; e.lat += 1 + wr; end
            7'h33: begin e.op = 2; e.rw = 1; end
            7'h63: begin e.op = 1; e.br = 1; end
            7'h37: begin e.src = 1; e.op = 3; e.rw = 1; end
            7'h17: begin e.src = 1; e.rw = 1; end
            7'h6f: begin e.jmp = 1; e.rw = 1; end
            7'h67: begin e.jmp = 1; e.rw = 1; e.src = 1; end
            7'h73: if (w == 32'h0010_0073) e.halt = 1;
            7'h1b: if (w_en) begin e.src = 1; e.op = 2; e.rw = 1; e.word = 1; end
                   else begin e.halt = 1; e.err = 1; end
            7'h3b: if (w_en) begin e.op = 2; e.rw = 1; e.word = 1; end
                   else begin e.halt = 1; e.err = 1; end
            default: begin e.halt = 1; e.err = 1; end
        endcase
        return e;
    endfunction

    function automatic logic [17:0] all_outs();
        return {ifu_req_valid, mem_req_valid, mem_we, alu_src, alu_op, alu_word, mem2reg,
                reg_write, pc_write, branch, jump, halt, err, state};
    endfunction

    // Monitor: pops one record per retirement (pc_write) or per halt entry.
    initial begin
        exp_t e;
        bit   halt_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pc_write || (halt && !halt_prev)) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: pc_write=%0b halt=%0b, want none",
                                 pc_write, halt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("halt_flag", halt, e.halt);
                        chk("err_code", err, e.err);
                        if (pc_write) begin
                            chk("controls", {alu_src, alu_op, alu_word, mem2reg, reg_write,
                                             branch, jump},
                                {e.src, e.op, e.word, e.m2r, e.rw, e.br, e.jmp});
                            chk("latency", cyc - fetch_start + 1, e.lat);
                        end
                    end
                end
                if (!pc_write) chk("reg_write_outside_wb", reg_write, 0);
                if (!mem_req_valid) chk("mem_we_outside_mem", mem_we, 0);
                if (halt) chk("halt_quiet", {ifu_req_valid, mem_req_valid, mem_we, reg_write,
                                             pc_write}, 0);
            end
            halt_prev = halt;
        end
    end

    task automatic do_reset();
        #2 rst = 1'b1;
        exp_q.delete();
        ifu_req_ready = 0; ifu_resp_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        #1 chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("fetch_after_release", ifu_req_valid, 1);
    endtask

    task automatic fetch(input logic [31:0] w, input int wr, input int wv);
        int k = 0;
        while (!ifu_req_valid && k < 40) begin @(negedge clk); k++; end
        chk("fetch_request", ifu_req_valid, 1);
        fetch_start = cyc;
        repeat (wr) @(negedge clk);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        repeat (wv) begin instr = $urandom; @(negedge clk); end
        instr = w;
        ifu_resp_valid = 1'b1;
        @(negedge clk);
        ifu_resp_valid = 1'b0;
        instr = $urandom;
    endtask

    task automatic mem(input bit store, input int wr, input int wm);
        int k = 0;
        int good = 0;
        while (!mem_req_valid && k < 20) begin @(negedge clk); k++; end
        chk("mem_request", mem_req_valid, 1);
        for (int i = 0; i <= wr; i++) begin
            if (mem_req_valid && (mem_we == store)) good++;
            if (i == wr) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        chk("mem_req_hold", good, wr + 1);
        if (!store) begin
            repeat (wm) @(negedge clk);
            mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic wait_halt(output int k);
        k = 0;
        while (!halt && k < 40) begin @(negedge clk); k++; end
        chk("halt_reached", halt, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic exec(input logic [31:0] w, input int wi, input int wv, input int wr,
                        input int wm);
        exp_t e = model(w, wi, wv, wr, wm);
        int   k;
        exp_q.push_back(e);
        fetch(w, wi, wv);
        if (e.halt) wait_halt(k);
        else if (e.mem) mem(e.store, wr, wm);
    endtask

    initial begin
        logic [6:0]  ops[10] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6f,
                                 7'h67, 7'h73};
        logic [31:0] w;
        exp_t        e;
        int          k;

        ifu_req_ready = 0; ifu_resp_valid = 0; instr = 0; mem_req_ready = 0;
        mem_resp_valid = 0;
        do_reset();

        exec(32'h0050_0093, 0, 0, 0, 0);   // addi, zero-wait
        exec(32'h0000_3083, 0, 0, 0, 3);   // ld, response 3 cycles late
        exec(32'h0010_3023, 0, 0, 10, 0);  // sd, ready low 10 cycles

        for (int i = 0; i < 60; i++) begin
            w = {$urandom_range(0, 33554431), ops[$urandom_range(0, 9)]};
            if (w == 32'h0010_0073) w[20] = 1'b0;
            exec(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                 $urandom_range(0, 4));
        end

        exec(32'h0000_0000, 0, 0, 0, 0);   // illegal opcode
        do_reset();
        exec(32'h0010_0073, 1, 1, 0, 0);   // ebreak
        do_reset();
        exec(32'h0000_003B, 0, 0, 0, 0);   // addw: legal only with word ops enabled
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin @(negedge clk); k++; end
        do_reset();

        // Fetch never accepted: timeout after exactly TO cycles.
        e = '{default: 0};
        e.halt = 1; e.err = 2;
        exp_q.push_back(e);
        wait_halt(k);
        chk("fetch_timeout_cycles", k, TO);
        do_reset();

        // Fetch accepted in the last allowed cycle: no error.
        exec(32'h0050_0093, TO - 1, 0, 0, 0);
        exec(32'h0000_3083, 0, TO - 1, TO - 1, TO - 1);

        // Store never accepted: timeout in MEM.
        exp_q.push_back(e);
        fetch(32'h0010_3023, 0, 0);
        k = 0;
        while (!mem_req_valid && k < 20) begin @(negedge clk); k++; end
        chk("mem_request", mem_req_valid, 1);
        wait_halt(k);
        chk("mem_timeout_cycles", k, TO);
        do_reset();

        // Reset while waiting for a load response.
        exp_q.push_back(model(32'h0000_3083, 0, 0, 0, 0));
        fetch(32'h0000_3083, 0, 0);
        k = 0;
        while (!mem_req_valid && k < 20) begin @(negedge clk); k++; end
        chk("mem_request", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("in_waitm_no_wb", pc_write, 0);
        do_reset();
        exec(32'h0050_0093, 0, 0, 0, 0);

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
